// File: rtl/complex_addsub_issue_pkg.sv
// Shared definitions for the complex add/sub issue block: complex word layout and op encoding.
package complex_addsub_issue_pkg;

  localparam int CPLX_W = 64;
  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic [RE_MSB-RE_LSB:0] re;
    logic [IM_MSB-IM_LSB:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
    logic  op;
  } cplx_op_t;

endpackage

// File: rtl/complex_addsub_issue_fifo.sv
// Operand FIFO for the issue block: circular buffer with head always visible on o_rdata.
module cplx_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 133
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == CNTW'(0));

endmodule

// File: rtl/complex_addsub_issue.sv
// Issue/tracking control for an external complex adder-subtractor: queues operations,
// feeds the arithmetic pipe and follows each op's tag through it, stalling on output backpressure.
module complex_addsub_issue
  import complex_addsub_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int TAGW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CPLX_W-1:0]      in_a,
  input  logic [CPLX_W-1:0]      in_b,
  input  logic                   in_op,
  input  logic [TAGW-1:0]        in_tag,
  output logic [CPLX_W-1:0]      issue_a,
  output logic [CPLX_W-1:0]      issue_b,
  output logic                   issue_op,
  output logic                   issue_ce,
  input  logic [CPLX_W-1:0]      res_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CPLX_W-1:0]      out_data,
  output logic [TAGW-1:0]        out_tag,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNTW    = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = $bits(cplx_op_t) + TAGW;

  typedef struct packed {
    cplx_op_t        cop;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t          w_wentry;
  entry_t          w_head;
  logic [CNTW-1:0] w_count;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_ce;

  logic [LATENCY-1:0] r_vld;
  logic [TAGW-1:0]    r_tag [LATENCY];

  assign w_wentry = '{cop: '{a: in_a, b: in_b, op: in_op}, tag: in_tag};

  assign in_ready = (w_count < CNTW'(DEPTH));
  assign w_push   = in_valid & in_ready;
  // The arithmetic pipe freezes only when a finished result is being held back.
  assign w_ce     = ~(r_vld[LATENCY-1] & ~out_ready);
  assign w_pop    = w_ce & ~w_empty;

  cplx_op_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Valid/tag shadow of the arithmetic pipe, advancing in lock-step with issue_ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (w_ce) begin
      r_vld[0] <= ~w_empty;
      r_tag[0] <= w_head.tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end else begin
      r_vld <= r_vld;
    end
  end

  assign issue_a    = w_head.cop.a;
  assign issue_b    = w_head.cop.b;
  assign issue_op   = w_head.cop.op;
  assign issue_ce   = w_ce;
  assign out_valid  = r_vld[LATENCY-1];
  assign out_tag    = r_tag[LATENCY-1];
  assign out_data   = res_data;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_complex_addsub_issue.sv
// Self-checking bench: behavioural complex adder-subtractor beside the DUT, directed tables,
// corner sequences and a randomized run against an in-order scoreboard.
module tb_complex_addsub_issue;
  import complex_addsub_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int TAGW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CPLX_W-1:0] in_a;
  logic [CPLX_W-1:0] in_b;
  logic              in_op;
  logic [TAGW-1:0]   in_tag;
  logic [CPLX_W-1:0] issue_a;
  logic [CPLX_W-1:0] issue_b;
  logic              issue_op;
  logic              issue_ce;
  logic [CPLX_W-1:0] res_data;
  logic              out_valid;
  logic              out_ready;
  logic [CPLX_W-1:0] out_data;
  logic [TAGW-1:0]   out_tag;
  logic [2:0]        fifo_count;

  always #5 clk = ~clk;

  complex_addsub_issue #(.DEPTH(DEPTH), .LATENCY(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op), .issue_ce(issue_ce),
    .res_data(res_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .fifo_count(fifo_count)
  );

  // Single-precision <-> real conversions (normal numbers and zero only).
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] b;
    if (x[30:23] == 8'd0) return 0.0;
    b = {x[31], {3'd0, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [63:0] cplx_ref(input logic [63:0] a, input logic [63:0] b, input logic op);
    real re;
    real im;
    if (op == OP_ADD) begin
      re = sp2r(a[RE_MSB:RE_LSB]) + sp2r(b[RE_MSB:RE_LSB]);
      im = sp2r(a[IM_MSB:IM_LSB]) + sp2r(b[IM_MSB:IM_LSB]);
    end else begin
      re = sp2r(a[RE_MSB:RE_LSB]) - sp2r(b[RE_MSB:RE_LSB]);
      im = sp2r(a[IM_MSB:IM_LSB]) - sp2r(b[IM_MSB:IM_LSB]);
    end
    return {r2sp(re), r2sp(im)};
  endfunction

  function automatic logic [63:0] rnd_cplx();
    int re;
    int im;
    re = int'($urandom_range(2000)) - 1000;
    im = int'($urandom_range(2000)) - 1000;
    return {r2sp(real'(re)), r2sp(real'(im))};
  endfunction

  // Stand-in for the external complex adder-subtractor: LAT-stage pipe frozen by ce.
  logic [63:0] r_alu [LAT];
  always_ff @(posedge clk) begin
    if (issue_ce) begin
      r_alu[0] <= cplx_ref(issue_a, issue_b, issue_op);
      for (int i = 1; i < LAT; i++) r_alu[i] <= r_alu[i-1];
    end
  end
  assign res_data = r_alu[LAT-1];

  typedef struct {
    logic [63:0]     data;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [63:0]     a;
    logic [63:0]     b;
    logic            op;
    logic [TAGW-1:0] tag;
    logic [63:0]     exp;
  } vec_t;
  vec_t vecs[5];

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int n_out = 0;
  logic            pushed;
  logic            xfer;
  logic [TAGW-1:0] last_tag;
  logic [63:0]     last_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, evaluate the handshakes that the next rising edge will see.
  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic op, input logic [TAGW-1:0] tag, input logic ordy);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = ordy;
    #1;
    check("in_ready_vs_count", in_ready, 64'(fifo_count < 3'd4));
    check("issue_ce_rule", issue_ce, 64'(!(out_valid && !out_ready)));
    pushed = v && in_ready;
    if (pushed) begin
      sb.push_back('{data: cplx_ref(a, b, op), tag: tag});
      n_acc++;
    end
    xfer = out_valid && out_ready;
    if (xfer) begin
      n_out++;
      last_tag = out_tag;
      last_data = out_data;
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 64'd0, 64'd0, OP_SUB, '0, ordy);
  endtask

  task automatic drain(input int bound);
    int g = 0;
    while (sb.size() > 0 && g < bound) begin
      idle(1'b1);
      g++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic fill_until(input int target, input int tag0);
    int g = 0;
    while (fifo_count != 3'(target) && g < 30) begin
      step(1'b1, rnd_cplx(), rnd_cplx(), 1'($urandom_range(1)), TAGW'(tag0 + g), 1'b0);
      g++;
    end
    check("fill_count", 64'(fifo_count), 64'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base_acc, base_out, first_i, last_i, nx, acc, cyc, exp_tag;

    vecs[0] = '{64'h3F800000_40000000, 64'h3F800000_3F800000, OP_ADD, 4'd5,  64'h40000000_40400000};
    vecs[1] = '{64'h40400000_40000000, 64'h3F800000_3F800000, OP_SUB, 4'd9,  64'h40000000_3F800000};
    vecs[2] = '{64'h3F800000_3F800000, 64'h3F800000_3F800000, OP_SUB, 4'd3,  64'h00000000_00000000};
    vecs[3] = '{64'h40000000_C0000000, 64'h40000000_40000000, OP_ADD, 4'd15, 64'h40800000_00000000};
    vecs[4] = '{64'h3F000000_40800000, 64'h3E800000_3F800000, OP_SUB, 4'd0,  64'h3E800000_40400000};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_issue_ce", 64'(issue_ce), 64'(1));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations: value, tag and accept-to-valid latency.
    for (int v = 0; v < 5; v++) begin
      step(1'b1, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].tag, 1'b1);
      k = 0;
      xfer = 1'b0;
      while (!xfer && k < 20) begin
        idle(1'b1);
        k++;
      end
      check("single_latency", 64'(k), 64'(LAT + 1));
      check("single_data", last_data, vecs[v].exp);
      check("single_tag", 64'(last_tag), 64'(vecs[v].tag));
    end

    // Back-to-back eight ops: eight consecutive results, tags 0..7.
    nx = 0; first_i = -1; last_i = -1; exp_tag = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 8) step(1'b1, rnd_cplx(), rnd_cplx(), 1'($urandom_range(1)), TAGW'(i), 1'b1);
      else idle(1'b1);
      if (xfer) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        nx++;
        check("b2b_tag", 64'(last_tag), 64'(exp_tag));
        exp_tag++;
      end
    end
    check("b2b_count", 64'(nx), 64'(8));
    check("b2b_span", 64'(last_i - first_i), 64'(7));

    // Fill with output stalled, then release.
    base_acc = n_acc; base_out = n_out;
    for (int i = 0; i < 12; i++) step(1'b1, rnd_cplx(), rnd_cplx(), 1'($urandom_range(1)), TAGW'(i), 1'b0);
    in_valid = 1'b0;
    #1;
    check("fill_accepted", 64'(n_acc - base_acc), 64'(DEPTH + LAT));
    check("fill_count4", 64'(fifo_count), 64'(DEPTH));
    check("fill_in_ready", 64'(in_ready), 64'(0));
    check("fill_issue_ce", 64'(issue_ce), 64'(0));
    check("fill_out_valid", 64'(out_valid), 64'(1));
    drain(50);
    check("fill_results", 64'(n_out - base_out), 64'(DEPTH + LAT));

    // Simultaneous push and pop with two entries queued.
    fill_until(2, 0);
    base_out = n_out;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_cplx(), rnd_cplx(), 1'($urandom_range(1)), TAGW'(i + 3), 1'b1);
      check("pp_count", 64'(fifo_count), 64'(2));
    end
    drain(50);
    check("pp_results", 64'(n_out - base_out), 64'(LAT + 2 + 10));

    // Reset in the middle of activity discards everything.
    fill_until(3, 4);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base_out = n_out;
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("post_rst_no_result", 64'(n_out - base_out), 64'(0));

    // Randomized traffic against the scoreboard.
    acc = 0; cyc = 0; base_out = n_out;
    while (acc < 1000 && cyc < 20000) begin
      step(1'($urandom_range(1)), rnd_cplx(), rnd_cplx(), 1'($urandom_range(1)),
           TAGW'($urandom_range(15)), 1'($urandom_range(1)));
      if (pushed) acc++;
      cyc++;
    end
    check("rand_accepted", 64'(acc), 64'(1000));
    drain(200);
    check("rand_results", 64'(n_out - base_out), 64'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_addsub_issue.md
COMPLEX_ADDSUB_ISSUE -- requirements
Module: complex_addsub_issue

Interface
REQ-001 Parameter: DEPTH, 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter: LATENCY, 3, cycles from an issue edge to valid res_data at the complex adder-subtractor output (>=1).
REQ-003 Parameter: TAGW, 4, width of the user tag carried alongside each operation.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: in_valid  input  1  upstream offers an operation.
REQ-007 Port: in_ready  output  1  block accepts the operation this cycle.
REQ-008 Port: in_a  input  64  operand A, {real[63:32], imag[31:0]}, IEEE-754 single each.
REQ-009 Port: in_b  input  64  operand B, same format.
REQ-010 Port: in_op  input  1  1 = add, 0 = subtract; passed unchanged to the adder-subtractor.
REQ-011 Port: in_tag  input  TAGW  user tag.
REQ-012 Port: issue_a, issue_b  output  64 each  operands driven to the complex adder-subtractor A/B.
REQ-013 Port: issue_op  output  1  drives adder-subtractor op.
REQ-014 Port: issue_ce  output  1  drives adder-subtractor ce; 0 freezes its pipeline.
REQ-015 Port: res_data  input  64  result from the complex adder-subtractor.
REQ-016 Port: out_valid  output  1  out_data/out_tag hold a completed result.
REQ-017 Port: out_ready  input  1  downstream accepts the result.
REQ-018 Port: out_data  output  64  completed result, {real, imag}.
REQ-019 Port: out_tag  output  TAGW  tag of the result on out_data.
REQ-020 Port: fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-021 Input handshake: push occurs when in_valid & in_ready; in_ready = (fifo_count < DEPTH), no same-cycle bypass when full.
REQ-022 FIFO stores {in_a, in_b, in_op, in_tag}; circular read/write pointers wrap from DEPTH-1 to 0.
REQ-023 issue_a/issue_b/issue_op always reflect the FIFO head entry (head contents undefined-but-stable when empty).
REQ-024 Tracking pipe: LATENCY stages of {vld, tag}; advances only on cycles with issue_ce=1; holds otherwise.
REQ-025 On an advancing cycle, stage0 <= {1, head tag} and FIFO pops if fifo_count>0; else stage0 <= {0, x} (bubble), no pop.
REQ-026 issue_ce = ~(vld[LATENCY-1] & ~out_ready); combinational.
REQ-027 out_valid = vld[LATENCY-1]; out_tag = tag[LATENCY-1]; out_data = res_data (pass-through, stable while issue_ce=0).
REQ-028 Output transfer occurs when out_valid & out_ready; the same edge advances the pipe.
REQ-029 Simultaneous push and pop: fifo_count unchanged; pop reads old head, push writes tail.
REQ-030 Ordering: results leave in exact acceptance order; no drop, no duplication, under any in_valid/out_ready pattern.
REQ-031 Throughput: one operation per cycle sustained while in_valid=1 and out_ready=1.
REQ-032 Minimum latency in_valid accept to out_valid: LATENCY+1 cycles with empty FIFO.

Reset
REQ-033 rst_n=0 asynchronously clears pointers, fifo_count=0, all vld=0; hence out_valid=0, in_ready=1, issue_ce=1.
REQ-034 Reset mid-operation discards all queued and in-flight operations; no result is presented after release.
REQ-035 First push is accepted on the first rising edge with rst_n=1.

Structure
REQ-036 Shared package holds complex-word width 64, field split (real 63:32, imag 31:0) and the OP_ADD=1/OP_SUB=0 constants.
REQ-037 One sub-module: cplx_op_fifo (synchronous FIFO, DEPTH x (129+TAGW)); tracking pipe and control stay in the top.
REQ-038 Block instantiates no arithmetic; the complex adder-subtractor is instantiated beside it by the parent.

Verification
REQ-039 Single op: push A=0x3F800000_40000000, B=0x3F800000_3F800000, op=1, tag=5 -> out_valid at cycle LATENCY+1, out_data=0x40000000_40400000, out_tag=5.
REQ-040 Back-to-back 8 ops, out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order.
REQ-041 Fill: out_ready=0, in_valid=1 for 12 cycles -> LATENCY results in pipe, fifo_count=4, in_ready=0, issue_ce=0; release out_ready -> all 4+LATENCY results in order.
REQ-042 Simultaneous push/pop at fifo_count=2 -> fifo_count stays 2 over 10 cycles, no tag lost.
REQ-043 Assert rst_n=0 with fifo_count=3 and 3 in flight -> out_valid=0, fifo_count=0, in_ready=1 immediately; no result after release.
REQ-044 Random in_valid/out_ready (50%) for 1000 ops vs reference model -> all results matched in order.
